// File: rtl/reg_file_gen.sv
// reg_file_gen: banked register file with PC alias, two write ports, load scoreboard and sticky write-error flag.
// Optional same-cycle write-to-read bypass is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_gen #(
  parameter int WIDTH = 32,
  parameter int NREG  = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    a1,
  input  logic [AW-1:0]    a2,
  input  logic [AW-1:0]    a3,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] rd3,
  input  logic             we_a,
  input  logic [AW-1:0]    wa_a,
  input  logic [WIDTH-1:0] wd_a,
  input  logic             we_b,
  input  logic [AW-1:0]    wa_b,
  input  logic [WIDTH-1:0] wd_b,
  input  logic [WIDTH-1:0] pc_plus8,
  input  logic             mode,
  input  logic             ld_issue,
  input  logic [AW-1:0]    ld_rd,
  input  logic             ld_done,
  output logic             hazard,
  output logic             wr_err
);

  // Physical slots: 0..NREG-2 user bank, NREG-1 shadow SP, NREG shadow LR.
  localparam int          NPHYS = NREG + 1;
  localparam int          PW    = $clog2(NPHYS);
  localparam logic [AW:0] L_SP  = (AW+1)'(NREG - 3);
  localparam logic [AW:0] L_LR  = (AW+1)'(NREG - 2);
  localparam logic [AW:0] L_PC  = (AW+1)'(NREG - 1);

  function automatic logic f_valid(input logic [AW-1:0] a);
    return {1'b0, a} < L_PC;
  endfunction

  function automatic logic [PW-1:0] f_phys(input logic [AW-1:0] a, input logic m);
    logic [PW-1:0] p;
    p = PW'(a);
    if (m && ({1'b0, a} == L_SP)) begin
      p = PW'(NREG - 1);
    end else if (m && ({1'b0, a} == L_LR)) begin
      p = PW'(NREG);
    end
    return p;
  endfunction

  logic [WIDTH-1:0] r_regs [NPHYS];
  logic [NPHYS-1:0] r_pend;
  logic             r_wr_err;

  logic             w_a_ok;
  logic             w_b_ok;
  logic             w_err_set;
  logic             w_ld_ok;
  logic [PW-1:0]    w_pa;
  logic [PW-1:0]    w_pb;
  logic [PW-1:0]    w_pld;
  logic [NPHYS-1:0] w_pend_nxt;
  logic [AW-1:0]    w_ra  [3];
  logic [WIDTH-1:0] w_rd  [3];
  logic [2:0]       w_haz;

  always_comb begin
    w_a_ok    = we_a && f_valid(wa_a);
    w_b_ok    = we_b && f_valid(wa_b) && !(w_a_ok && (wa_b == wa_a));
    w_err_set = (we_a && !f_valid(wa_a)) || (we_b && !f_valid(wa_b));
    w_ld_ok   = f_valid(ld_rd);
    w_pa      = f_phys(wa_a, mode);
    w_pb      = f_phys(wa_b, mode);
    w_pld     = f_phys(ld_rd, mode);
  end

  // Done clears first, a port-A result clears, issue sets last so it wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (ld_done && w_ld_ok) begin
      w_pend_nxt[w_pld] = 1'b0;
    end
    if (w_a_ok) begin
      w_pend_nxt[w_pa] = 1'b0;
    end
    if (ld_issue && w_ld_ok) begin
      w_pend_nxt[w_pld] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPHYS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_b_ok) begin
        r_regs[w_pb] <= wd_b;
      end
      if (w_a_ok) begin
        r_regs[w_pa] <= wd_a;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend   <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_err_set) begin
        r_wr_err <= 1'b1;
      end
    end
  end

  assign w_ra[0] = a1;
  assign w_ra[1] = a2;
  assign w_ra[2] = a3;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      w_rd[p]  = '0;
      w_haz[p] = 1'b0;
      if ({1'b0, w_ra[p]} == L_PC) begin
        w_rd[p] = pc_plus8;
      end else if (f_valid(w_ra[p])) begin
        w_rd[p]  = r_regs[f_phys(w_ra[p], mode)];
        w_haz[p] = r_pend[f_phys(w_ra[p], mode)];
`ifdef REG_FILE_BYPASS_EN
        if (w_a_ok && (w_ra[p] == wa_a)) begin
          w_rd[p]  = wd_a;
          w_haz[p] = 1'b0;
        end else if (w_b_ok && (w_ra[p] == wa_b)) begin
          w_rd[p] = wd_b;
        end
`endif
      end
    end
  end

  assign rd1    = w_rd[0];
  assign rd2    = w_rd[1];
  assign rd3    = w_rd[2];
  assign hazard = |w_haz;
  assign wr_err = r_wr_err;

endmodule
